// File: rtl/uart_rx_bridge.sv
// uart_rx_bridge: receive side of the CPLD UART link.
// Synchronises data_ready, arbitrates for the shared ram1 data bus, strobes rdn,
// captures the byte and queues it in a small FIFO popped by the memory stage.
// Optional feature macro: UART_RX_FLOW_CTRL_EN (back-pressure instead of overrun).
`timescale 1ns/1ps
module uart_rx_bridge #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned RD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_ready,
    output logic       rdn,
    input  logic [7:0] bus_data,
    output logic       bus_req,
    input  logic       bus_gnt,
    input  logic       pop,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [4:0] rx_count,
    output logic       overrun,
    input  logic       clr_ovr
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_STROBE,
        S_CAPTURE,
        S_RELEASE
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_rdn;
    logic          r_bus_req;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_overrun;

    logic [PW-1:0] w_count;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_write;
    logic          w_lost;
    logic          w_can_start;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == FULL_CNT);
    assign w_pop   = pop & (w_count != '0);
    assign w_push  = (r_state == S_CAPTURE);
    // a pop in the capture cycle frees the slot, so a full FIFO still accepts the byte
    assign w_write = w_push & (~w_full | w_pop);

`ifdef UART_RX_FLOW_CTRL_EN
    // leave the byte in the CPLD until there is room for it
    assign w_can_start = ~w_full;
    assign w_lost      = 1'b0;
`else
    assign w_can_start = 1'b1;
    assign w_lost      = w_push & w_full & ~w_pop;
`endif

    assign rdn      = r_rdn;
    assign bus_req  = r_bus_req;
    assign rx_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign rx_valid = (w_count != '0);
    assign rx_count = 5'(w_count);
    assign overrun  = r_overrun;

    // two-flop synchroniser for the asynchronous data_ready level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= data_ready;
            r_sync2 <= r_sync1;
        end
    end

    // read sequencer: request bus, hold rdn low RD_CYCLES+1 cycles, release, wait for ready drop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rdn     <= 1'b1;
            r_bus_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_sync2 && w_can_start) begin
                        r_state   <= S_REQ;
                        r_bus_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        r_state <= S_STROBE;
                        r_rdn   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_CAPTURE: begin
                    r_state   <= S_RELEASE;
                    r_rdn     <= 1'b1;
                    r_bus_req <= 1'b0;
                end
                S_RELEASE: begin
                    if (!r_sync2) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_rdn     <= 1'b1;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage and pointers; bus_data is written on the edge that ends CAPTURE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr[AW-1:0]] <= bus_data;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // sticky overrun flag; a new loss wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (w_lost) begin
            r_overrun <= 1'b1;
        end else if (clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_bridge.sv
// tb_uart_rx_bridge: directed bench for uart_rx_bridge with a byte scoreboard.
// Stimulus pushes expected bytes into a queue; a monitor pops and compares on every CPU pop.
`timescale 1ns/1ps
module tb_uart_rx_bridge;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned RD_CYCLES = 2;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       data_ready = 1'b0;
    logic       bus_gnt    = 1'b1;
    logic       pop        = 1'b0;
    logic       clr_ovr    = 1'b0;
    logic [7:0] bus_data   = 8'h00;
    logic       rdn;
    logic       bus_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] rx_count;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_bridge #(.DEPTH(DEPTH), .RD_CYCLES(RD_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_ready (data_ready),
        .rdn        (rdn),
        .bus_data   (bus_data),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .pop        (pop),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_count   (rx_count),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: inputs change at negedge, so sample just after it
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (pop === 1'b1 && rx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h want none", rx_data);
                end else begin
                    check("sb_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic pop_one();
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    task automatic wait_rdn_low(input string name);
        int n = 0;
        while (rdn !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_rdn_fall"}, {31'h0, rdn}, 32'h0);
    endtask

    // entered at a negedge with rdn low; counts low cycles, CPLD drops ready after the read
    task automatic finish_read(input logic [7:0] b, input bit pop_cap, input bit store, output int low);
        low = 0;
        while (rdn === 1'b0 && low < 20) begin
            low++;
            if (pop_cap && low == int'(RD_CYCLES) + 1) pop = 1'b1;
            @(negedge clk);
            pop = 1'b0;
        end
        if (store) exp_q.push_back(b);
        data_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input string name, input logic [7:0] b, input bit pop_cap, input bit store);
        int low;
        @(negedge clk);
        bus_data   = b;
        data_ready = 1'b1;
        wait_rdn_low(name);
        finish_read(b, pop_cap, store, low);
        check({name, "_rdn_low_cycles"}, low, RD_CYCLES + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        repeat (3) @(negedge clk);
        check("rst_rdn", {31'h0, rdn}, 32'h1);
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_rx_count", {27'h0, rx_count}, 32'h0);
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single byte with grant already present
        send_byte("t1", 8'h41, 1'b0, 1'b1);
        check("t1_valid", {31'h0, rx_valid}, 32'h1);
        check("t1_data", {24'h0, rx_data}, 32'h41);
        check("t1_count", {27'h0, rx_count}, 32'h1);
        pop_one();
        check("t1_drained", {27'h0, rx_count}, 32'h0);

        // grant withheld for 10 cycles
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_data   = 8'h5A;
        data_ready = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_req_rdn", {30'h0, bus_req, rdn}, 32'h3);
            @(negedge clk);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        check("t2_rdn_after_gnt", {31'h0, rdn}, 32'h0);
        finish_read(8'h5A, 1'b0, 1'b1, low);
        check("t2_rdn_low_cycles", low, RD_CYCLES + 1);
        pop_one();

        // fill the FIFO
        for (int i = 1; i <= 8; i++) send_byte("t3_fill", 8'(i), 1'b0, 1'b1);
        check("t3_count_full", {27'h0, rx_count}, 32'h8);
`ifdef UART_RX_FLOW_CTRL_EN
        @(negedge clk);
        bus_data   = 8'hFF;
        data_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("t3_fc_hold_rdn_req", {30'h0, rdn, bus_req}, 32'h2);
            @(negedge clk);
        end
        pop_one();
        wait_rdn_low("t3_fc");
        finish_read(8'hFF, 1'b0, 1'b1, low);
        check("t3_fc_overrun", {31'h0, overrun}, 32'h0);
        check("t3_fc_count", {27'h0, rx_count}, 32'h8);
        repeat (8) pop_one();
`else
        send_byte("t3_ovr", 8'hFF, 1'b0, 1'b0);
        check("t3_overrun", {31'h0, overrun}, 32'h1);
        check("t3_head", {24'h0, rx_data}, 32'h01);
        check("t3_count", {27'h0, rx_count}, 32'h8);
        @(negedge clk);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check("t3_overrun_clr", {31'h0, overrun}, 32'h0);

        // full FIFO, pop in the capture cycle
        send_byte("t4", 8'h55, 1'b1, 1'b1);
        check("t4_count", {27'h0, rx_count}, 32'h8);
        check("t4_overrun", {31'h0, overrun}, 32'h0);
        repeat (8) pop_one();
`endif
        check("t4_drained_count", {27'h0, rx_count}, 32'h0);
        check("t4_drained_valid", {31'h0, rx_valid}, 32'h0);

        // pop on empty, then push/pop pairs across the pointer wrap
        pop_one();
        check("t5_empty_count", {27'h0, rx_count}, 32'h0);
        check("t5_empty_valid", {31'h0, rx_valid}, 32'h0);
        for (int i = 0; i < 12; i++) begin
            send_byte("t5", 8'(8'h10 + i), 1'b0, 1'b1);
            pop_one();
        end
        check("t5_final_count", {27'h0, rx_count}, 32'h0);

        // reset in the middle of the strobe
        @(negedge clk);
        bus_data   = 8'h77;
        data_ready = 1'b1;
        wait_rdn_low("t6");
        #1;
        rst = 1'b0;
        #1;
        check("t6_async_rdn", {31'h0, rdn}, 32'h1);
        check("t6_async_bus_req", {31'h0, bus_req}, 32'h0);
        data_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_valid", {31'h0, rx_valid}, 32'h0);
        check("t6_count", {27'h0, rx_count}, 32'h0);
        check("t6_rdn_idle", {31'h0, rdn}, 32'h1);

        check("sb_queue_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
